lfsr_decrypt_seq: RTL and testbench

- Sequencer for the LFSR decryption datapath. Drives the data memory read/write ports and the load/enable of the six parallel lfsr6b instances.
- Identifies which of the six tap patterns produced the ciphertext by checking each LFSR against the known preamble.
- Writes the decrypted payload back to memory and raises done.
- Replaces the hard-coded cycle_ct case table in the top level with a parameterised FSM.

---
 rtl/lfsr_decrypt_seq.sv | 179 +++++++++++++++++
 tb/tb_lfsr_decrypt_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_seq.sv
// lfsr_decrypt_seq: sequencer for the six-way LFSR decryption datapath.
// Seeds every LFSR from the first ciphertext byte. It then drops any LFSR whose
// keystream disagrees with the known preamble, and uses the surviving LFSR
// (highest index wins) to decrypt the payload back into memory.
module lfsr_decrypt_seq #(
  parameter int unsigned RD_BASE  = 64,
  parameter int unsigned WR_BASE  = 0,
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned PRE_LEN  = 7,
  parameter logic [7:0]  PRE_CHAR = 8'h5F,
  parameter int unsigned NUM_TAPS = 6
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  start,
  output logic [7:0]            mem_raddr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_wr_en,
  output logic                  lfsr_load,
  output logic                  lfsr_en,
  output logic [5:0]            lfsr_start,
  input  logic [6*NUM_TAPS-1:0] lfsr_states,
  output logic [2:0]            tap_sel,
  output logic                  no_match,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_TRAIN,
    S_DECRYPT,
    S_DONE
  } state_t;

  // cnt equals k during cycle Tk of a run.
  localparam logic [8:0] TRAIN_LAST = 9'(PRE_LEN);      // last preamble compare
  localparam logic [8:0] SYNC_CNT   = 9'(PRE_LEN + 1);  // sync byte, tap selection
  localparam logic [8:0] LAST_CNT   = 9'(MSG_LEN);      // final payload write
  localparam logic [8:0] RD_LAST    = 9'(MSG_LEN - 1);  // final read offset
  localparam logic [7:0] RD_BASE8   = 8'(RD_BASE);
  localparam logic [7:0] WR_BASE8   = 8'(WR_BASE);
  localparam logic [7:0] WR_SKEW    = 8'(PRE_LEN + 2);  // first write happens in T(PRE_LEN+2)
  localparam logic [5:0] PRE_KEY    = PRE_CHAR[5:0];

  state_t              state, state_nx;
  logic [8:0]          cnt;
  logic [NUM_TAPS-1:0] cand;
  logic [NUM_TAPS-1:0] match;
  logic [2:0]          sel;
  logic [7:0]          data_q;
  logic [5:0]          key_q;
  logic [5:0]          tap_state [NUM_TAPS];
  logic [8:0]          rd_off;
  logic [7:0]          rd_next;

  // Split the flat LFSR bus into per-tap states and compare each one to the expected key.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_state[i] = lfsr_states[6*i +: 6];
      match[i]     = (tap_state[i] == key_q);
    end
  end

  // Priority-encode the surviving candidates; the highest index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (cand[i]) sel = 3'(i);
    end
  end

  // Read address for the next byte. It saturates at the last ciphertext byte.
  always_comb begin
    rd_off  = (cnt >= RD_LAST) ? RD_LAST : cnt + 9'd1;
    rd_next = RD_BASE8 + rd_off[7:0];
  end

  // NOTE: data_q/key_q are a free-running pipeline overwritten every cycle and never
  // read before being refilled, so they deliberately carry no reset.
  // Capture the byte returned by memory together with its preamble-key view.
  always_ff @(posedge clk) begin
    data_q <= mem_rdata;
    key_q  <= mem_rdata[5:0] ^ PRE_KEY;
  end

  // State register. An asynchronous reset returns the FSM to IDLE, which also
  // drops mem_wr_en immediately.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Run bookkeeping: the cycle counter, the candidate mask and the result flags.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cnt      <= '0;
      cand     <= '1;
      tap_sel  <= '0;
      no_match <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt      <= '0;
            cand     <= '1;  // re-arm every tap for the new run
            tap_sel  <= '0;
            no_match <= 1'b0;
          end
        end
        S_SEED: cnt <= cnt + 9'd1;
        S_TRAIN: begin
          cnt  <= cnt + 9'd1;
          cand <= cand & match;
        end
        S_DECRYPT: begin
          cnt <= cnt + 9'd1;
          if (cnt == SYNC_CNT) begin
            if (cand == '0) no_match <= 1'b1;
            else            tap_sel  <= sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign lfsr_start = mem_rdata[5:0] ^ PRE_KEY;
  assign done       = (state == S_DONE);

  // NOTE: every output and next-state term gets a default before the case, so no
  // path through this block can leave a latch behind.
  // Next-state logic plus the memory and LFSR strobes.
  always_comb begin
    state_nx  = state;
    mem_raddr = RD_BASE8;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_SEED;
      end
      S_SEED: begin
        lfsr_load = 1'b1;
        mem_raddr = rd_next;
        state_nx  = S_TRAIN;
      end
      S_TRAIN: begin
        lfsr_en   = 1'b1;
        mem_raddr = rd_next;
        if (cnt == TRAIN_LAST) state_nx = S_DECRYPT;
      end
      S_DECRYPT: begin
        mem_raddr = rd_next;
        if (cnt == SYNC_CNT) begin
          // The sync byte is only consumed. The LFSR holds still, so the first
          // payload byte is paired with S(PRE_LEN).
          if (cand == '0) state_nx = S_DONE;
        end else begin
          mem_wr_en = 1'b1;
          lfsr_en   = 1'b1;
          mem_waddr = WR_BASE8 + cnt[7:0] - WR_SKEW;
          mem_wdata = data_q ^ {2'b00, tap_state[tap_sel]};
          if (cnt == LAST_CNT) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_nx = S_SEED;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// Bench for lfsr_decrypt_seq. It models the memory and six LFSRs and encrypts
// messages. When a message is built, the expected plaintext writes are queued;
// they are popped and compared when the DUT writes.
module tb_lfsr_decrypt_seq;

  localparam int         RD_BASE  = 64;
  localparam int         WR_BASE  = 0;
  localparam int         MSG_LEN  = 64;
  localparam int         PRE_LEN  = 7;
  localparam int         NUM_TAPS = 6;
  localparam logic [7:0] PRE_CHAR = 8'h5F;
  localparam int         N_WRITES = MSG_LEN - PRE_LEN - 1;
  localparam logic [5:0] TAPS [NUM_TAPS] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic                  clk;
  logic                  init_n;
  logic                  start;
  logic [7:0]            mem_raddr;
  logic [7:0]            mem_rdata;
  logic [7:0]            mem_waddr;
  logic [7:0]            mem_wdata;
  logic                  mem_wr_en;
  logic                  lfsr_load;
  logic                  lfsr_en;
  logic [5:0]            lfsr_start;
  logic [6*NUM_TAPS-1:0] lfsr_states;
  logic [2:0]            tap_sel;
  logic                  no_match;
  logic                  done;

  logic [7:0] mem  [256];
  logic [5:0] lfsr [NUM_TAPS];
  wr_t        exp_q [$];
  int         cyc = 0;
  int         e0 = 0;
  int         nwrites = 0;
  int         asserts = 0;
  int         failures = 0;

  lfsr_decrypt_seq #(
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .MSG_LEN(MSG_LEN), .PRE_LEN(PRE_LEN),
    .PRE_CHAR(PRE_CHAR), .NUM_TAPS(NUM_TAPS)
  ) dut (
    .clk(clk), .init_n(init_n), .start(start),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .lfsr_start(lfsr_start),
    .lfsr_states(lfsr_states), .tap_sel(tap_sel), .no_match(no_match), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  // Memory with a one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  // Reference LFSR models.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (lfsr_load)    lfsr[i] <= lfsr_start;
      else if (lfsr_en) lfsr[i] <= step(lfsr[i], TAPS[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) lfsr_states[6*i +: 6] = lfsr[i];
  end

  // Search for a seed under which only tap idx matches the whole preamble.
  // The search starts at 6'h15.
  function automatic logic [5:0] find_seed(input int idx);
    logic [5:0] s, a, b;
    bit uniq, same;
    for (int n = 0; n < 63; n++) begin
      s    = 6'(((20 + n) % 63) + 1);
      uniq = 1'b1;
      for (int j = 0; j < NUM_TAPS; j++) begin
        if (j != idx) begin
          a = s; b = s; same = 1'b1;
          for (int k = 1; k < PRE_LEN; k++) begin
            a = step(a, TAPS[idx]);
            b = step(b, TAPS[j]);
            if (a != b) same = 1'b0;
          end
          if (same) uniq = 1'b0;
        end
      end
      if (uniq) return s;
    end
    return 6'd0;
  endfunction

  // Encrypt a message for tap idx. Without corruption, the expected plaintext
  // writes are queued. With corruption, byte C3 carries a key that no LFSR can produce.
  task automatic load_message(input int idx, input logic [5:0] seed, input bit corrupt);
    logic [5:0] s, v, x;
    logic [7:0] p;
    bit hit;
    exp_q.delete();
    s = seed;
    for (int k = 0; k < PRE_LEN; k++) begin
      mem[RD_BASE + k] = PRE_CHAR ^ {2'b00, s};
      s = step(s, TAPS[idx]);
    end
    mem[RD_BASE + PRE_LEN] = 8'($urandom);
    for (int a = 0; a < N_WRITES; a++) begin
      p = 8'($urandom);
      mem[RD_BASE + PRE_LEN + 1 + a] = p ^ {2'b00, s};
      if (!corrupt) exp_q.push_back('{addr: 8'(WR_BASE + a), data: p});
      s = step(s, TAPS[idx]);
    end
    if (corrupt) begin
      for (int c = 0; c < 64; c++) begin
        v = 6'(c);
        hit = 1'b0;
        for (int j = 0; j < NUM_TAPS; j++) begin
          x = seed;
          for (int k = 0; k < 3; k++) x = step(x, TAPS[j]);
          if (x == v) hit = 1'b1;
        end
        if (!hit) begin
          mem[RD_BASE + 3] = PRE_CHAR ^ {2'b00, v};
          break;
        end
      end
    end
  endtask

  // Hold start high across exactly one rising edge (E0). Return in T0.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    nwrites = 0;
  endtask

  // Step the negative edges until T(stop_rel) or until done is seen. Any write on
  // the way is popped from the scoreboard and compared.
  task automatic run_until(input int stop_rel, output int lat);
    wr_t w;
    lat = -1;
    while ((cyc - e0) < stop_rel && lat < 0) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wr_en === 1'b1) begin
        nwrites++;
        asserts++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write T%0d: addr=%0h data=%0h, none required",
                   cyc - e0, mem_waddr, mem_wdata);
        end else begin
          w = exp_q.pop_front();
          if (mem_waddr !== w.addr || mem_wdata !== w.data) begin
            failures++;
            $display("FAIL write T%0d: addr=%0h data=%0h, required addr=%0h data=%0h",
                     cyc - e0, mem_waddr, mem_wdata, w.addr, w.data);
          end
        end
      end
      if (done === 1'b1) lat = cyc - e0;
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    asserts++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
    asserts++; if (no_match !== 1'b0)   begin failures++; $display("FAIL reset_no_match: got %b, required 0", no_match); end
    asserts++; if (mem_wr_en !== 1'b0)  begin failures++; $display("FAIL reset_wr_en: got %b, required 0", mem_wr_en); end
    asserts++; if (lfsr_load !== 1'b0 || lfsr_en !== 1'b0)
      begin failures++; $display("FAIL reset_lfsr_ctl: got load=%b en=%b, required 0 0", lfsr_load, lfsr_en); end
    asserts++; if (tap_sel !== 3'd0)    begin failures++; $display("FAIL reset_tap_sel: got %0d, required 0", tap_sel); end
    asserts++; if (mem_raddr !== 8'(RD_BASE))
      begin failures++; $display("FAIL reset_raddr: got %0h, required %0h", mem_raddr, RD_BASE); end
    init_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_decrypt_tap(input int idx);
    logic [5:0] seed;
    int lat;
    seed = find_seed(idx);
    asserts++; if (seed === 6'd0) begin failures++; $display("FAIL seed_search tap%0d: got 0, required a unique seed", idx); end
    load_message(idx, seed, 1'b0);
    pulse_start();
    asserts++; if (lfsr_load !== 1'b1 || lfsr_start !== seed)
      begin failures++; $display("FAIL seed tap%0d: got load=%b start=%0h, required 1 %0h", idx, lfsr_load, lfsr_start, seed); end
    run_until(MSG_LEN + 20, lat);
    asserts++; if (lat !== MSG_LEN + 1)
      begin failures++; $display("FAIL done_latency tap%0d: got %0d, required %0d", idx, lat, MSG_LEN + 1); end
    asserts++; if (tap_sel !== 3'(idx))
      begin failures++; $display("FAIL tap_sel tap%0d: got %0d, required %0d", idx, tap_sel, idx); end
    asserts++; if (no_match !== 1'b0)
      begin failures++; $display("FAIL no_match tap%0d: got %b, required 0", idx, no_match); end
    asserts++; if (nwrites !== N_WRITES || exp_q.size() != 0)
      begin failures++; $display("FAIL write_count tap%0d: got %0d (left %0d), required %0d", idx, nwrites, exp_q.size(), N_WRITES); end
  endtask

  task automatic test_no_match();
    int lat;
    load_message(3, 6'h15, 1'b1);
    pulse_start();
    run_until(MSG_LEN + 20, lat);
    asserts++; if (lat !== PRE_LEN + 2)
      begin failures++; $display("FAIL nomatch_latency: got %0d, required %0d", lat, PRE_LEN + 2); end
    asserts++; if (no_match !== 1'b1)
      begin failures++; $display("FAIL nomatch_flag: got %b, required 1", no_match); end
    asserts++; if (nwrites !== 0)
      begin failures++; $display("FAIL nomatch_writes: got %0d, required 0", nwrites); end
    asserts++; if (tap_sel !== 3'd0)
      begin failures++; $display("FAIL nomatch_tap_sel: got %0d, required 0", tap_sel); end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_message(3, 6'h15, 1'b0);
    pulse_start();
    run_until(30, lat);
    #2;
    asserts++; if (mem_wr_en !== 1'b1)
      begin failures++; $display("FAIL midreset_pre_wr_en: got %b, required 1", mem_wr_en); end
    init_n = 1'b0;
    #1;
    asserts++; if (mem_wr_en !== 1'b0)
      begin failures++; $display("FAIL midreset_wr_en_async: got %b, required 0", mem_wr_en); end
    asserts++; if (done !== 1'b0 || lfsr_en !== 1'b0)
      begin failures++; $display("FAIL midreset_done_en: got done=%b en=%b, required 0 0", done, lfsr_en); end
    asserts++; if (mem_raddr !== 8'(RD_BASE))
      begin failures++; $display("FAIL midreset_idle_raddr: got %0h, required %0h", mem_raddr, RD_BASE); end
    @(negedge clk);
    init_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    test_decrypt_tap(3);
  endtask

  task automatic test_start_busy();
    int lat;
    load_message(5, find_seed(5), 1'b0);
    pulse_start();
    run_until(20, lat);
    start = 1'b1;
    run_until(MSG_LEN + 20, lat);
    asserts++; if (lat !== MSG_LEN + 1)
      begin failures++; $display("FAIL busy_latency: got %0d, required %0d", lat, MSG_LEN + 1); end
    asserts++; if (tap_sel !== 3'd5)
      begin failures++; $display("FAIL busy_tap_sel: got %0d, required 5", tap_sel); end
    asserts++; if (nwrites !== N_WRITES || exp_q.size() != 0)
      begin failures++; $display("FAIL busy_writes: got %0d (left %0d), required %0d", nwrites, exp_q.size(), N_WRITES); end
  endtask

  task automatic test_back_to_back();
    int lat;
    repeat (5) @(negedge clk);
    asserts++; if (done !== 1'b1 || mem_raddr !== 8'(RD_BASE))
      begin failures++; $display("FAIL done_sticky: got done=%b raddr=%0h, required 1 %0h", done, mem_raddr, RD_BASE); end
    load_message(1, find_seed(1), 1'b0);
    pulse_start();
    asserts++; if (done !== 1'b0 || lfsr_load !== 1'b1)
      begin failures++; $display("FAIL restart_from_done: got done=%b load=%b, required 0 1", done, lfsr_load); end
    run_until(MSG_LEN + 20, lat);
    asserts++; if (lat !== MSG_LEN + 1)
      begin failures++; $display("FAIL b2b_latency: got %0d, required %0d", lat, MSG_LEN + 1); end
    asserts++; if (tap_sel !== 3'd1)
      begin failures++; $display("FAIL b2b_tap_sel: got %0d, required 1", tap_sel); end
    asserts++; if (nwrites !== N_WRITES || exp_q.size() != 0)
      begin failures++; $display("FAIL b2b_writes: got %0d (left %0d), required %0d", nwrites, exp_q.size(), N_WRITES); end
  endtask

  initial begin
    init_n = 1'b0;
    start  = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_decrypt_tap(3);
    test_decrypt_tap(0);
    test_decrypt_tap(1);
    test_decrypt_tap(2);
    test_decrypt_tap(4);
    test_decrypt_tap(5);
    test_no_match();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
